// File: rtl/hcsr04_multi_ctrl_pkg.sv
// Shared definitions for the multi-channel HC-SR04 controller:
// state encodings, debug codes and default timing constants.
package hcsr04_multi_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_PREPARACAO    = 4'd1,
    ST_ENVIA_TRIGGER = 4'd2,
    ST_ESPERA_ECHO   = 4'd3,
    ST_MEDIDA        = 4'd4,
    ST_ARMAZENA      = 4'd5,
    ST_INTERVALO     = 4'd6,
    ST_FINAL         = 4'd15
  } state_e;

  localparam logic [3:0] DB_ILLEGAL = 4'd14;

  localparam int DEF_N_CH           = 2;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEF_GAP_CYCLES     = 3_000_000;

  // Legal states report their own encoding; anything else reports the illegal code.
  function automatic logic [3:0] db_code(input state_e st);
    case (st)
      ST_INICIAL, ST_PREPARACAO, ST_ENVIA_TRIGGER, ST_ESPERA_ECHO,
      ST_MEDIDA, ST_ARMAZENA, ST_INTERVALO, ST_FINAL: db_code = st;
      default: db_code = DB_ILLEGAL;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hcsr04_multi_ctrl_sync.sv
// Parametrised-width two-flop synchronizer with asynchronous active-low clear.
module hcsr04_sync #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/hcsr04_multi_ctrl.sv
// Multi-channel HC-SR04 controller: sweeps the sensors in order, generates the
// trigger, times the echo width with one shared timer and reports one result per channel.
module hcsr04_multi_ctrl
  import hcsr04_multi_ctrl_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int MW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            medir,
  input  logic            continuo,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic [MW-1:0]   medida,
  output logic [CH_W-1:0] canal,
  output logic            valido,
  output logic            timeout,
  output logic            pronto,
  output logic            ocupado,
  output logic [3:0]      db_estado
);

  localparam int TW = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);

  state_e          state_r, state_nx_s;
  logic [TW-1:0]   timer_r, timer_nx_s;
  logic [CH_W-1:0] idx_r, idx_nx_s;
  logic            tmo_r, tmo_nx_s;
  logic [N_CH-1:0] echo_sync_s;
  logic            echo_sel_s;
  logic [N_CH-1:0] trigger_dec_s;

  logic [N_CH-1:0] trigger_r;
  logic [MW-1:0]   medida_r;
  logic [CH_W-1:0] canal_r;
  logic            valido_r;
  logic            timeout_r;
  logic            pronto_r;
  logic            ocupado_r;
  logic [3:0]      db_estado_r;

  hcsr04_sync #(.W(N_CH)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (echo),
    .q       (echo_sync_s)
  );

  assign echo_sel_s = echo_sync_s[idx_r];

  // State, timer, channel index and timeout flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INICIAL;
      timer_r <= '0;
      idx_r   <= '0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      timer_r <= timer_nx_s;
      idx_r   <= idx_nx_s;
      tmo_r   <= tmo_nx_s;
    end
  end

  // Next-state logic; the timer saturates at TIMEOUT_CYCLES in MEDIDA and never wraps.
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    idx_nx_s   = idx_r;
    tmo_nx_s   = tmo_r;
    case (state_r)
      ST_INICIAL: begin
        if (medir) begin
          state_nx_s = ST_PREPARACAO;
          idx_nx_s   = '0;
        end else begin
          state_nx_s = ST_INICIAL;
        end
      end
      ST_PREPARACAO: begin
        timer_nx_s = '0;
        state_nx_s = ST_ENVIA_TRIGGER;
      end
      ST_ENVIA_TRIGGER: begin
        if (timer_r == TW'(TRIG_CYCLES - 1)) begin
          state_nx_s = ST_ESPERA_ECHO;
          timer_nx_s = '0;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      ST_ESPERA_ECHO: begin
        // The rise cycle is the first counted cycle of the echo width.
        if (echo_sel_s) begin
          state_nx_s = ST_MEDIDA;
          timer_nx_s = TW'(1);
        end else if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nx_s = ST_ARMAZENA;
          tmo_nx_s   = 1'b1;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      ST_MEDIDA: begin
        if (!echo_sel_s) begin
          state_nx_s = ST_ARMAZENA;
          tmo_nx_s   = 1'b0;
        end else if (timer_r >= TW'(TIMEOUT_CYCLES - 1)) begin
          state_nx_s = ST_ARMAZENA;
          timer_nx_s = TW'(TIMEOUT_CYCLES);
          tmo_nx_s   = 1'b1;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      ST_ARMAZENA: begin
        timer_nx_s = '0;
        state_nx_s = ST_INTERVALO;
      end
      ST_INTERVALO: begin
        if (timer_r == TW'(GAP_CYCLES - 1)) begin
          timer_nx_s = '0;
          if (idx_r < CH_W'(N_CH - 1)) begin
            idx_nx_s   = idx_r + CH_W'(1);
            state_nx_s = ST_PREPARACAO;
          end else begin
            state_nx_s = ST_FINAL;
          end
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      ST_FINAL: begin
        if (continuo) begin
          state_nx_s = ST_PREPARACAO;
          idx_nx_s   = '0;
        end else begin
          state_nx_s = ST_INICIAL;
        end
      end
      default: begin
        state_nx_s = ST_INICIAL;
        timer_nx_s = '0;
        idx_nx_s   = '0;
        tmo_nx_s   = 1'b0;
      end
    endcase
  end

  // One-hot trigger decode for the selected channel.
  always_comb begin
    trigger_dec_s = '0;
    if (state_r == ST_ENVIA_TRIGGER) begin
      trigger_dec_s[idx_r] = 1'b1;
    end else begin
      trigger_dec_s = '0;
    end
  end

  // Output registers; the result fields only change when a measurement is stored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trigger_r   <= '0;
      medida_r    <= '0;
      canal_r     <= '0;
      valido_r    <= 1'b0;
      timeout_r   <= 1'b0;
      pronto_r    <= 1'b0;
      ocupado_r   <= 1'b0;
      db_estado_r <= 4'd0;
    end else begin
      trigger_r   <= trigger_dec_s;
      valido_r    <= (state_r == ST_ARMAZENA);
      pronto_r    <= (state_r == ST_FINAL);
      ocupado_r   <= (state_r != ST_INICIAL);
      db_estado_r <= db_code(state_r);
      if (state_r == ST_ARMAZENA) begin
        medida_r  <= tmo_r ? MW'(TIMEOUT_CYCLES) : timer_r[MW-1:0];
        canal_r   <= idx_r;
        timeout_r <= tmo_r;
      end else begin
        medida_r  <= medida_r;
        canal_r   <= canal_r;
        timeout_r <= timeout_r;
      end
    end
  end

  assign trigger   = trigger_r;
  assign medida    = medida_r;
  assign canal     = canal_r;
  assign valido    = valido_r;
  assign timeout   = timeout_r;
  assign pronto    = pronto_r;
  assign ocupado   = ocupado_r;
  assign db_estado = db_estado_r;

endmodule

// File: tb/tb_hcsr04_multi_ctrl.sv
// Scoreboard bench for hcsr04_multi_ctrl: per-channel echo drivers follow a
// plan queue, a reference model predicts each result, a monitor checks every valido.
module tb_hcsr04_multi_ctrl;

  localparam int N_CH = 2;
  localparam int TRIG = 4;
  localparam int TMO  = 100;
  localparam int GAP  = 10;
  localparam int CH_W = 1;
  localparam int MW   = $clog2(TMO + 1);

  typedef struct {
    int ch;
    int d;
    int w;
    bit never;
  } plan_t;

  typedef struct {
    int ch;
    int medida;
    bit tmo;
    bit lat;
  } exp_t;

  logic            clock;
  logic            reset_n;
  logic            medir;
  logic            continuo;
  wire  [N_CH-1:0] echo_s;
  logic [N_CH-1:0] noise_s;
  logic [N_CH-1:0] trigger_s;
  logic [MW-1:0]   medida_s;
  logic [CH_W-1:0] canal_s;
  logic            valido_s;
  logic            timeout_s;
  logic            pronto_s;
  logic            ocupado_s;
  logic [3:0]      db_estado_s;

  plan_t plan_q [N_CH][$];
  exp_t  exp_q [$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    valido_cnt = 0;
  int    pronto_cnt = 0;

  hcsr04_multi_ctrl #(
    .N_CH           (N_CH),
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .medir     (medir),
    .continuo  (continuo),
    .echo      (echo_s),
    .trigger   (trigger_s),
    .medida    (medida_s),
    .canal     (canal_s),
    .valido    (valido_s),
    .timeout   (timeout_s),
    .pronto    (pronto_s),
    .ocupado   (ocupado_s),
    .db_estado (db_estado_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the result follows from the echo plan alone.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    e.ch  = p.ch;
    e.lat = p.never;
    if (p.never || p.w >= TMO) begin
      e.medida = TMO;
      e.tmo    = 1'b1;
    end else begin
      e.medida = p.w;
      e.tmo    = 1'b0;
    end
    return e;
  endfunction

  task automatic plan_meas(input int ch, input int d, input int w, input bit never);
    plan_t p;
    p.ch = ch; p.d = d; p.w = w; p.never = never;
    plan_q[ch].push_back(p);
    exp_q.push_back(model(p));
  endtask

  task automatic plan_random_sweep();
    for (int c = 0; c < N_CH; c++) begin
      plan_meas(c, int'($urandom_range(0, 60)), int'($urandom_range(1, 100)),
                $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic pulse_medir();
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
  endtask

  task automatic wait_pronto(input int target, input string name);
    int n = 0;
    while (pronto_cnt < target && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check(name, pronto_cnt, target);
  endtask

  task automatic wait_state(input int code, input string name);
    int n = 0;
    while (int'(db_estado_s) != code && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(db_estado_s), code);
  endtask

  // Echo drivers: after each trigger fall, play the next planned pulse on that channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_drv
    logic e_r = 1'b0;
    assign echo_s[g] = e_r | noise_s[g];
    initial begin
      plan_t p;
      forever begin
        @(negedge trigger_s[g]);
        @(negedge clock);
        if (plan_q[g].size() != 0) begin
          p = plan_q[g].pop_front();
          if (!p.never) begin
            repeat (p.d) @(negedge clock);
            e_r = 1'b1;
            repeat (p.w) @(negedge clock);
            e_r = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: scoreboard on valido, trigger width/one-hot, timeout latency.
  initial begin
    int run [N_CH];
    int fall_cyc [N_CH];
    int dl;
    logic [N_CH-1:0] prev;
    exp_t e;
    prev = '0;
    for (int c = 0; c < N_CH; c++) begin
      run[c] = 0;
      fall_cyc[c] = 0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      if (valido_s) begin
        valido_cnt++;
        check("valido_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("canal", int'(canal_s), e.ch);
          check("medida", int'(medida_s), e.medida);
          check("timeout", int'(timeout_s), int'(e.tmo));
          if (e.lat) begin
            dl = cyc - fall_cyc[e.ch];
            check("timeout_latency", (dl == TMO + 1) ? TMO : dl, TMO);
          end
        end
      end
      if (pronto_s) pronto_cnt++;
      if (trigger_s != '0) check("trigger_onehot", int'($onehot(trigger_s)), 1);
      for (int c = 0; c < N_CH; c++) begin
        if (trigger_s[c]) begin
          run[c]++;
        end else if (prev[c]) begin
          check("trigger_width", run[c], TRIG);
          run[c] = 0;
          fall_cyc[c] = cyc;
        end
      end
      prev = trigger_s;
    end
  end

  initial begin
    int n;
    int p0;
    int v0;
    reset_n  = 1'b0;
    medir    = 1'b0;
    continuo = 1'b0;
    noise_s  = '0;
    repeat (3) @(negedge clock);
    check("rst_trigger", int'(trigger_s), 0);
    check("rst_valido", int'(valido_s), 0);
    check("rst_pronto", int'(pronto_s), 0);
    check("rst_ocupado", int'(ocupado_s), 0);
    check("rst_medida", int'(medida_s), 0);
    check("rst_db_estado", int'(db_estado_s), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // 1: two normal channels, plus medir-to-trigger latency
    p0 = pronto_cnt;
    plan_meas(0, 5, 37, 1'b0);
    plan_meas(1, 8, 12, 1'b0);
    @(negedge clock) medir = 1'b1;
    @(posedge clock);
    #1 medir = 1'b0;
    n = 0;
    while (!trigger_s[0] && n < 10) begin
      @(posedge clock);
      #1 n++;
    end
    check("medir_to_trigger", n, 2);
    wait_pronto(p0 + 1, "t1_pronto");
    repeat (20) @(negedge clock);
    check("t1_drained", exp_q.size(), 0);
    check("t1_idle", int'(ocupado_s), 0);

    // 2: channel 1 echo never rises
    p0 = pronto_cnt;
    plan_meas(0, 4, 20, 1'b0);
    plan_meas(1, 0, 0, 1'b1);
    pulse_medir();
    wait_pronto(p0 + 1, "t2_pronto");
    repeat (20) @(negedge clock);

    // 3: channel 0 echo far too long, channel 1 still measured
    p0 = pronto_cnt;
    plan_meas(0, 2, 250, 1'b0);
    plan_meas(1, 6, 30, 1'b0);
    pulse_medir();
    wait_pronto(p0 + 1, "t3_pronto");
    repeat (200) @(negedge clock);

    // 4: continuous mode for three sweeps, released during the third
    p0 = pronto_cnt;
    v0 = valido_cnt;
    for (int s = 0; s < 3; s++) plan_random_sweep();
    continuo = 1'b1;
    pulse_medir();
    wait_pronto(p0 + 2, "t4_pronto2");
    continuo = 1'b0;
    wait_pronto(p0 + 3, "t4_pronto3");
    repeat (50) @(negedge clock);
    check("t4_pronto_total", pronto_cnt - p0, 3);
    check("t4_valido_total", valido_cnt - v0, 6);
    check("t4_idle", int'(ocupado_s), 0);
    check("t4_db_estado", int'(db_estado_s), 0);

    // 5: reset while measuring
    v0 = valido_cnt;
    plan_meas(0, 5, 80, 1'b0);
    pulse_medir();
    wait_state(4, "t5_reach_medida");
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5_trigger", int'(trigger_s), 0);
    check("t5_valido", int'(valido_s), 0);
    check("t5_pronto", int'(pronto_s), 0);
    check("t5_db_estado", int'(db_estado_s), 0);
    check("t5_ocupado", int'(ocupado_s), 0);
    exp_q.delete();
    @(negedge clock) reset_n = 1'b1;
    repeat (300) @(negedge clock);
    check("t5_no_valido", valido_cnt - v0, 0);
    check("t5_idle", int'(ocupado_s), 0);

    // 6: medir and a channel-1 echo while channel 0 is being measured
    p0 = pronto_cnt;
    plan_meas(0, 3, 60, 1'b0);
    plan_meas(1, 5, 25, 1'b0);
    pulse_medir();
    wait_state(4, "t6_reach_medida");
    @(negedge clock);
    noise_s[1] = 1'b1;
    medir = 1'b1;
    repeat (2) @(negedge clock);
    medir = 1'b0;
    repeat (15) @(negedge clock);
    noise_s[1] = 1'b0;
    wait_pronto(p0 + 1, "t6_pronto");
    repeat (100) @(negedge clock);
    check("t6_no_restart", pronto_cnt - p0, 1);
    check("t6_idle", int'(ocupado_s), 0);

    // 7: random single-shot sweeps
    for (int s = 0; s < 4; s++) begin
      p0 = pronto_cnt;
      plan_random_sweep();
      pulse_medir();
      wait_pronto(p0 + 1, "t7_pronto");
      repeat (20) @(negedge clock);
    end
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
